// File: rtl/pwm_dac_pkg.sv
// Shared register map, CTRL bit positions and datapath helpers for pwm_dac.
// Pure definitions: no latency, no flow control.
package pwm_dac_pkg;

    localparam logic [1:0] REG_CTRL     = 2'd0;
    localparam logic [1:0] REG_PRESCALE = 2'd1;
    localparam logic [1:0] REG_VOLUME   = 2'd2;
    localparam logic [1:0] REG_STATUS   = 2'd3;

    localparam int CTRL_EN  = 0;
    localparam int CTRL_INV = 1;

    localparam int PERIOD_W = 8;

    // sample * (vol + 1) peaks at 255 * 256, so bits [15:8] never overflow.
    function automatic logic [7:0] scale_level(input logic [7:0] lvl, input logic [7:0] vol);
        logic [15:0] prod;
        prod = {8'd0, lvl} * {7'd0, ({1'b0, vol} + 9'd1)};
        return prod[15:8];
    endfunction

    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] r;
        r = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) r[8*b +: 8] = new_val[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/pwm_dac_core.sv
// Prescaler, 256-tick period counter, duty latch and comparator.
// Raw PWM bit is combinational from registered cnt/duty; no backpressure.
module pwm_dac_core
    import pwm_dac_pkg::*;
#(
    parameter int PRESCALE_W = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  en_i,
    input  logic                  restart_i,
    input  logic                  pre_clr_i,
    input  logic [PRESCALE_W-1:0] prescale_i,
    input  logic [PERIOD_W-1:0]   level_i,
    output logic                  wrap_o,
    output logic                  pwm_raw_o,
    output logic [PERIOD_W-1:0]   duty_o
);

    logic [PRESCALE_W-1:0] pre_q, pre_d;
    logic [PERIOD_W-1:0]   cnt_q, cnt_d;
    logic [PERIOD_W-1:0]   duty_q, duty_d;
    logic                  tick;

    assign tick   = en_i && (pre_q == prescale_i);
    assign wrap_o = tick && (cnt_q == '1);

    always_comb begin
        pre_d  = pre_q;
        cnt_d  = cnt_q;
        duty_d = duty_q;
        if (!en_i || restart_i || pre_clr_i || tick) pre_d = '0;
        else                                         pre_d = pre_q + PRESCALE_W'(1);
        if (!en_i || restart_i) cnt_d = '0;
        else if (tick)          cnt_d = cnt_q + PERIOD_W'(1);
        // Duty survives disable; it only moves on a period boundary or a fresh enable.
        if (restart_i || wrap_o) duty_d = level_i;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pre_q  <= '0;
            cnt_q  <= '0;
            duty_q <= '0;
        end else begin
            pre_q  <= pre_d;
            cnt_q  <= cnt_d;
            duty_q <= duty_d;
        end
    end

    assign pwm_raw_o = (cnt_q < duty_q);
    assign duty_o    = duty_q;

endmodule

// File: rtl/pwm_dac.sv
// Memory-mapped 1-bit PWM audio DAC; bus ready pulses 1 cycle after accept, one transaction per 2 cycles.
// Optional PWM_DAC_FADE_EN: cur_vol ramps by 1 per PWM period toward VOLUME instead of copying it.
module pwm_dac
    import pwm_dac_pkg::*;
#(
    parameter int PRESCALE_W = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        valid,
    output logic        ready,
    input  logic [3:0]  wstrb,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic [7:0]  sample,
    output logic        pwm_out
);

    logic                  en_q, en_d, inv_q, inv_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic [7:0]            volume_q, volume_d;
    logic                  ready_q;
    logic [31:0]           rdata_q, rdata_d, rd_val;
    logic                  pwm_q;
    logic [7:0]            cur_vol, level, duty;
    logic                  wrap, pwm_raw;
    logic                  accept, wr_en, restart, pre_clr;
    logic [1:0]            sel;
    logic [31:0]           ctrl_merged, pre_merged, vol_merged;

    assign sel    = addr[3:2];
    assign accept = valid && !ready_q;
    assign wr_en  = accept && (wstrb != 4'd0);

    always_comb begin
        ctrl_merged = byte_merge({30'd0, inv_q, en_q}, wdata, wstrb);
        pre_merged  = byte_merge(32'(prescale_q), wdata, wstrb);
        vol_merged  = byte_merge({24'd0, volume_q}, wdata, wstrb);
        en_d        = en_q;
        inv_d       = inv_q;
        prescale_d  = prescale_q;
        volume_d    = volume_q;
        if (wr_en) begin
            case (sel)
                REG_CTRL: begin
                    en_d  = ctrl_merged[CTRL_EN];
                    inv_d = ctrl_merged[CTRL_INV];
                end
                REG_PRESCALE: prescale_d = pre_merged[PRESCALE_W-1:0];
                REG_VOLUME:   volume_d   = vol_merged[7:0];
                default: ;
            endcase
        end
    end

    assign restart = wr_en && (sel == REG_CTRL) && !en_q && ctrl_merged[CTRL_EN];
    assign pre_clr = wr_en && (sel == REG_PRESCALE);

    always_comb begin
        rd_val = 32'd0;
        case (sel)
            REG_CTRL:     rd_val = {30'd0, inv_q, en_q};
            REG_PRESCALE: rd_val = 32'(prescale_q);
            REG_VOLUME:   rd_val = {24'd0, volume_q};
            default:      rd_val = {16'd0, cur_vol, duty};
        endcase
    end

    assign rdata_d = accept ? rd_val : rdata_q;

`ifdef PWM_DAC_FADE_EN
    logic [7:0] cur_vol_q, cur_vol_d;

    always_comb begin
        cur_vol_d = cur_vol_q;
        if (wrap) begin
            if (cur_vol_q < volume_q)      cur_vol_d = cur_vol_q + 8'd1;
            else if (cur_vol_q > volume_q) cur_vol_d = cur_vol_q - 8'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) cur_vol_q <= '0;
        else         cur_vol_q <= cur_vol_d;
    end

    assign cur_vol = cur_vol_q;
`else
    assign cur_vol = volume_q;
`endif

    // Level is built from the pre-write cur_vol, so a wrap coinciding with a VOLUME write uses the old volume.
    assign level = scale_level(sample, cur_vol);

    pwm_dac_core #(
        .PRESCALE_W (PRESCALE_W)
    ) u_core (
        .clk        (clk),
        .resetn     (resetn),
        .en_i       (en_q),
        .restart_i  (restart),
        .pre_clr_i  (pre_clr),
        .prescale_i (prescale_q),
        .level_i    (level),
        .wrap_o     (wrap),
        .pwm_raw_o  (pwm_raw),
        .duty_o     (duty)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            en_q       <= 1'b0;
            inv_q      <= 1'b0;
            prescale_q <= '0;
            volume_q   <= '0;
            ready_q    <= 1'b0;
            rdata_q    <= '0;
            pwm_q      <= 1'b0;
        end else begin
            en_q       <= en_d;
            inv_q      <= inv_d;
            prescale_q <= prescale_d;
            volume_q   <= volume_d;
            ready_q    <= accept;
            rdata_q    <= rdata_d;
            pwm_q      <= en_q ? (pwm_raw ^ inv_q) : 1'b0;
        end
    end

    assign ready   = ready_q;
    assign rdata   = rdata_q;
    assign pwm_out = pwm_q;

    logic unused_ok;
    assign unused_ok = ^{addr[31:4], addr[1:0], ctrl_merged, pre_merged, vol_merged, wrap};

endmodule
